// File: rtl/sof_token_builder_if.sv
// Byte stream from the SOF token builder to the SIE packet encoder.
// Valid/ready handshake; tok_last marks the final byte of a token.
interface sof_token_builder_if;
   logic [7:0] tok_data;
   logic       tok_valid;
   logic       tok_last;
   logic       tok_ready;

   modport master (output tok_data, output tok_valid, output tok_last, input tok_ready);
   modport slave  (input tok_data, input tok_valid, input tok_last, output tok_ready);
endinterface

// File: rtl/sof_token_builder.sv
// Builds the 3-byte USB SOF token (PID, frame[10:0], CRC5) from a sof strobe.
// CRC5 is computed bit-serially, then the token is streamed to the SIE encoder.
module sof_token_builder #(
   parameter logic [7:0] SOF_PID   = 8'hA5,
   parameter logic [4:0] CRC5_POLY = 5'b00101,
   parameter logic [4:0] CRC5_INIT = 5'b11111
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        sof_i,
   input  logic [10:0]                 frame_num_sie_i,
   input  logic                        sie_busy_i,
   output logic                        sof_busy_o,
   output logic                        sof_sent_o,
   output logic                        sof_overrun_o,
   sof_token_builder_if.master         tok
);

   localparam int unsigned FRAME_W   = 11;
   localparam int unsigned CRC_W     = 5;
   localparam int unsigned BIT_CNT_W = 4;
   localparam int unsigned BYTE_W    = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_WAIT,
      S_B0,
      S_B1,
      S_B2
   } state_e;

   state_e               state_q, state_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic [CRC_W-1:0]     crc_q, crc_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

   logic                 fb;
   logic [CRC_W-1:0]     crc_field;
   logic [BYTE_W-1:0]    byte2;
   logic [BYTE_W-1:0]    tok_data;
   logic                 tok_valid;
   logic                 tok_last;
   logic                 sof_sent;

   // Transmitted CRC is the inverted remainder, most significant bit first.
   always_comb begin
      crc_field = '0;
      for (int i = 0; i < int'(CRC_W); i++) begin
         crc_field[i] = ~crc_q[CRC_W-1-i];
      end
   end

   assign byte2 = {crc_field, frame_q[FRAME_W-1:BYTE_W]};
   assign fb    = crc_q[CRC_W-1] ^ frame_q[bit_cnt_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         frame_q   <= '0;
         crc_q     <= CRC5_INIT;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         crc_q     <= crc_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      crc_d     = crc_q;
      bit_cnt_d = bit_cnt_q;
      tok_valid = 1'b0;
      tok_data  = '0;
      tok_last  = 1'b0;
      sof_sent  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sof_i) begin
               frame_d   = frame_num_sie_i;
               crc_d     = CRC5_INIT;
               bit_cnt_d = '0;
               state_d   = S_CALC;
            end
         end
         S_CALC: begin
            crc_d     = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC5_POLY : CRC_W'(0));
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            // Skip WAIT entirely when the SIE is already idle to keep B0 at cycle 12.
            if (bit_cnt_q == BIT_CNT_W'(FRAME_W - 1)) begin
               state_d = sie_busy_i ? S_WAIT : S_B0;
            end
         end
         S_WAIT: begin
            if (!sie_busy_i) begin
               state_d = S_B0;
            end
         end
         S_B0: begin
            tok_valid = 1'b1;
            tok_data  = SOF_PID;
            if (tok.tok_ready) begin
               state_d = S_B1;
            end
         end
         S_B1: begin
            tok_valid = 1'b1;
            tok_data  = frame_q[BYTE_W-1:0];
            if (tok.tok_ready) begin
               state_d = S_B2;
            end
         end
         S_B2: begin
            tok_valid = 1'b1;
            tok_data  = byte2;
            tok_last  = 1'b1;
            if (tok.tok_ready) begin
               sof_sent = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Stream outputs decode the state register; sent/overrun follow their inputs in-cycle.
   assign tok.tok_valid  = tok_valid;
   assign tok.tok_data   = tok_data;
   assign tok.tok_last   = tok_last;
   assign sof_sent_o     = sof_sent;
   assign sof_busy_o     = (state_q != S_IDLE);
   assign sof_overrun_o  = sof_i && (state_q != S_IDLE);

endmodule
